// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: beat/latency sequencer for the 2-lane N=32 radix-2^2 FFT pipeline.
// Define FFT_FRAME_CHECK_EN to add the frame_err / frame_cnt outputs.
module fft_seq_ctrl #(
  parameter int N         = 32,
  parameter int LOG2N     = 5,
  parameter int BLQ_DEPTH = 16,
  parameter int LAT       = 16,
  parameter int M         = N / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             flush,
  output logic             pipe_en,
  output logic             blq_ctrl,
  output logic [LOG2N-2:0] coeff0_addr,
  output logic [LOG2N-2:0] coeff1_addr,
  output logic             coeff1_en,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
`ifdef FFT_FRAME_CHECK_EN
  ,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int AW = LOG2N - 1;
  localparam int BW = $clog2(2 * BLQ_DEPTH);
  localparam int LW = $clog2(LAT + 1);
  localparam int IW = $clog2(M);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic [LW-1:0] lat_cnt, drain_cnt;
  logic [IW-1:0] out_idx;
  logic acc, drain_end;
  // next state, beat qualification and output framing
  always_comb begin
    state_nx    = state;
    acc         = rst && in_valid && state != DRAIN;
    pipe_en     = acc || (rst && state == DRAIN);
    drain_end   = state == DRAIN && drain_cnt == LW'(LAT - 1);
    beat_nx     = !pipe_en ? beat_cnt : beat_cnt == BW'(2 * BLQ_DEPTH - 1) ? '0 : beat_cnt + 1'b1;
    blq_ctrl    = beat_cnt >= BW'(BLQ_DEPTH);
    coeff0_addr = AW'(int'(beat_cnt) % M);
    coeff1_en   = lat_cnt >= LW'(BLQ_DEPTH);
    coeff1_addr = coeff1_en ? AW'((int'(beat_cnt) + M - BLQ_DEPTH % M) % M) : '0;
    out_valid   = pipe_en && (state == DRAIN ? drain_cnt >= LW'(LAT) - lat_cnt : lat_cnt >= LW'(LAT));
    out_first   = out_valid && out_idx == '0;
    out_last    = out_valid && out_idx == IW'(M - 1);
    busy        = state != IDLE;
    if (state == IDLE && in_valid)
      state_nx = FILL;
    else if ((state == FILL || state == RUN) && flush)
      state_nx = DRAIN;
    else if (state == FILL && acc && lat_cnt == LW'(LAT - 1))
      state_nx = RUN;
    else if (drain_end)
      state_nx = IDLE;
  end
  // state and counters; lat_cnt saturates at LAT so in DRAIN it equals the pending result count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      lat_cnt   <= '0;
      drain_cnt <= '0;
      out_idx   <= '0;
    end else begin
      state     <= state_nx;
      beat_cnt  <= drain_end ? '0 : beat_nx;
      lat_cnt   <= drain_end ? '0 : (acc && lat_cnt != LW'(LAT)) ? lat_cnt + 1'b1 : lat_cnt;
      drain_cnt <= drain_end ? '0 : state == DRAIN ? drain_cnt + 1'b1 : drain_cnt;
      out_idx   <= drain_end ? '0 : !out_valid ? out_idx : out_idx == IW'(M - 1) ? '0 : out_idx + 1'b1;
    end
  end
`ifdef FFT_FRAME_CHECK_EN
  // sticky partial-frame flag and completed output frame count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if ((state == FILL || state == RUN) && flush && int'(beat_nx) % M != 0)
        frame_err <= 1'b1;
      if (out_last)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: randomized scoreboard bench for fft_seq_ctrl against a stream-level model.
module tb_fft_seq_ctrl;
  localparam int N = 32, LOG2N = 5, BLQ = 16, LAT = 16, M = 16;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, flush = 1'b0;
  logic pipe_en, blq_ctrl, coeff1_en, out_valid, out_first, out_last, busy;
  logic [LOG2N-2:0] coeff0_addr, coeff1_addr;
`ifdef FFT_FRAME_CHECK_EN
  logic frame_err;
  logic [15:0] frame_cnt;
`endif
  int tests = 0, fails = 0;
  typedef struct {int due; int idx;} item_t;
  item_t q[$];
  int m_act = 0, m_acc = 0, m_beats = 0, m_drain = 0, m_frames = 0;
  bit m_err = 0;
  bit e_beat = 0, e_acc = 0, e_blq = 0, e_c1en = 0, e_busy = 0;
  int e_c0 = 0, e_c1 = 0, e_no = 0;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.N(N), .LOG2N(LOG2N), .BLQ_DEPTH(BLQ), .LAT(LAT), .M(M)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .pipe_en(pipe_en), .blq_ctrl(blq_ctrl), .coeff0_addr(coeff0_addr),
    .coeff1_addr(coeff1_addr), .coeff1_en(coeff1_en), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last), .busy(busy)
`ifdef FFT_FRAME_CHECK_EN
    , .frame_err(frame_err), .frame_cnt(frame_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // stream-level model: a result is due LAT beats after its input beat
  task automatic eval();
    e_acc  = rst && in_valid && m_act != 2;
    e_beat = e_acc || (rst && m_act == 2);
    e_no   = m_beats;
    e_blq  = (m_beats % (2 * BLQ)) >= BLQ;
    e_c0   = m_beats % M;
    e_c1en = m_acc >= BLQ;
    e_c1   = e_c1en ? (m_beats - BLQ) % M : 0;
    e_busy = m_act != 0;
    if (e_acc) q.push_back('{m_beats + LAT, m_acc % M});
  endtask

  task automatic update();
    int old;
    if (!rst) return;
    old = m_act;
    if (e_beat) m_beats++;
    if (e_acc) m_acc++;
    if (old == 0 && in_valid) m_act = 1;
    else if (old == 1 && flush) begin
      m_act = 2;
      if (m_beats % M != 0) m_err = 1;
    end else if (old == 2) begin
      m_drain++;
      if (m_drain == LAT) begin
        m_act = 0; m_acc = 0; m_beats = 0; m_drain = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit iv, input bit fl);
    rst = r; in_valid = iv; flush = fl;
    if (!r) begin
      m_act = 0; m_acc = 0; m_beats = 0; m_drain = 0; m_err = 0; m_frames = 0;
      q.delete();
    end
    eval();
    @(posedge clk); #1;
    update();
  endtask

  task automatic idle(input int n, input bit rnd_flush);
    for (int i = 0; i < n; i++) step(1, 0, rnd_flush ? ($urandom_range(0, 3) == 0) : 1'b0);
    chk("queue_empty", q.size(), 0);
    chk("busy_end", busy, 0);
  endtask

  // monitor: compare control outputs and pop the scoreboard on each result
  always @(negedge clk) begin : mon
    bit want;
    item_t it;
`ifdef FFT_FRAME_CHECK_EN
    chk("frame_err", frame_err, m_err);
    chk("frame_cnt", frame_cnt, m_frames);
`endif
    chk("pipe_en", pipe_en, e_beat);
    chk("blq_ctrl", blq_ctrl, e_blq);
    chk("coeff0_addr", coeff0_addr, e_c0);
    chk("coeff1_en", coeff1_en, e_c1en);
    chk("coeff1_addr", coeff1_addr, e_c1);
    chk("busy", busy, e_busy);
    want = e_beat && q.size() > 0 && q[0].due == e_no;
    chk("out_valid", out_valid, want);
    if (out_valid && q.size() > 0) begin
      it = q.pop_front();
      chk("out_first", out_first, it.idx == 0);
      chk("out_last", out_last, it.idx == M - 1);
      if (it.idx == M - 1) m_frames++;
    end else begin
      chk("out_first_idle", out_first, 0);
      chk("out_last_idle", out_last, 0);
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    idle(20, 0);
    for (int i = 0; i < 64; i++) step(1, 1, 0);
    step(1, 0, 1);
    idle(20, 0);
    for (int i = 0; i < 100; i++) step(1, (i % 5) < 2 || (i % 5) == 4, 0);
    step(1, 1, 1);
    idle(20, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    step(1, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 0, i == 3);
    chk("queue_empty", q.size(), 0);
    for (int i = 0; i < 40; i++) step(1, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0);
    step(1, 0, 1);
    idle(20, 0);
    for (int i = 0; i < 31; i++) step(1, 1, 0);
    step(1, 1, 1);
    idle(20, 0);
    for (int s = 0; s < 10; s++) begin
      int len;
      len = $urandom_range(1, 90);
      for (int i = 0; i < len; i++) step(1, $urandom_range(0, 3) != 0, 0);
      step(1, $urandom_range(0, 1), 1);
      idle(20, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
